// File: rtl/mac_drain.sv
// Drains buffered MAC accumulator bundles one lane per cycle, requantizing each lane to DATA_W.
// Optional feature: define MAC_DRAIN_RELU_EN to clamp negative requantized results to zero.
module mac_drain #(
    parameter int PAR        = 16,
    parameter int DATA_W     = 16,
    parameter int ACC_W      = 48,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 valid_in,
    input  logic [PAR*ACC_W-1:0]                 mac_in,
    input  logic [5:0]                           shift_amt,
    output logic                                 in_ready,
    output logic signed [DATA_W-1:0]             out_data,
    output logic [((PAR > 1) ? $clog2(PAR) : 1)-1:0] out_lane,
    output logic                                 out_last,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 overflow
);

    localparam int LANE_W = (PAR > 1) ? $clog2(PAR) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PAR - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);

    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W - DATA_W + 2){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W - DATA_W + 2){1'b1}}, {(DATA_W - 1){1'b0}}};

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    state_t               state;
    logic [PAR*ACC_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     count_next;
    logic [LANE_W-1:0]    lane_cnt;

    logic load;
    logic pop;
    logic push;
    logic drop;

    logic [PAR*ACC_W-1:0]   head;
    logic [ACC_W-1:0]       head_lane;
    logic [5:0]             s_eff;
    logic signed [ACC_W:0]  x_ext;
    logic signed [ACC_W:0]  rnd;
    logic signed [ACC_W:0]  sum_r;
    logic signed [ACC_W:0]  shifted;
    logic signed [DATA_W-1:0] q_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // A pop on the final lane frees a slot in the same cycle, so a push into a full buffer still succeeds.
    always_comb begin
        load       = (state == DRAIN) && (!out_valid || out_ready);
        pop        = load && (lane_cnt == LAST_LANE);
        push       = valid_in && ((count < FULL_CNT) || pop);
        drop       = valid_in && (count == FULL_CNT) && !pop;
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    assign in_ready = (count < FULL_CNT);

    // The extra bit keeps the rounding add from wrapping on the largest positive accumulator.
    always_comb begin
        head      = mem[rd_ptr];
        head_lane = head[lane_cnt*ACC_W +: ACC_W];
        s_eff     = (int'(shift_amt) > ACC_W - 1) ? 6'(ACC_W - 1) : shift_amt;
        x_ext     = {head_lane[ACC_W-1], head_lane};
        rnd       = '0;
        if (s_eff != 6'd0) begin
            rnd[s_eff - 6'd1] = 1'b1;
        end
        sum_r   = x_ext + rnd;
        shifted = sum_r >>> s_eff;
`ifdef MAC_DRAIN_RELU_EN
        if (shifted < 0) begin
            shifted = '0;
        end
`endif
        if (shifted > SAT_MAX) begin
            q_data = DATA_W'(SAT_MAX);
        end else if (shifted < SAT_MIN) begin
            q_data = DATA_W'(SAT_MIN);
        end else begin
            q_data = DATA_W'(shifted);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= mac_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            lane_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_lane  <= '0;
            out_last  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count_next;
            state <= (count_next != '0) ? DRAIN : IDLE;
            if (drop) begin
                overflow <= 1'b1;
            end
            if (load) begin
                out_data  <= q_data;
                out_lane  <= lane_cnt;
                out_last  <= (lane_cnt == LAST_LANE);
                out_valid <= 1'b1;
                lane_cnt  <= (lane_cnt == LAST_LANE) ? '0 : lane_cnt + 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
